// File: rtl/perf_event_accumulator.sv
// perf_event_accumulator: two-stage performance event counter bank.
// Event strobes are registered, reduced to per-counter increments and
// accumulated into eight wide counters with sticky overflow flags.
// The counters are reachable through a registered read port and a write port.
// Optional build macro PERF_COUNTER_OVF_IRQ_EN adds an overflow interrupt
// mask that is written through counter index 7 with the data MSB set.
module perf_event_accumulator #(
    parameter int FETCH_WIDTH       = 2,
    parameter int LOAD_ISSUE_WIDTH  = 1,
    parameter int STORE_ISSUE_WIDTH = 1,
    parameter int CNT_WIDTH         = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ev_ic_miss,
    input  logic [FETCH_WIDTH-1:0]       ev_br_pred,
    input  logic [LOAD_ISSUE_WIDTH-1:0]  ev_load_miss,
    input  logic [STORE_ISSUE_WIDTH-1:0] ev_store_miss,
    input  logic                         ev_stld_fwd_fail,
    input  logic                         ev_memdep_miss,
    input  logic                         ev_br_miss,
    input  logic                         ev_br_miss_dec,
    input  logic                         freeze,
    input  logic [7:0]                   inhibit,
    input  logic                         wr_en,
    input  logic [2:0]                   wr_idx,
    input  logic [CNT_WIDTH-1:0]         wr_data,
    input  logic [2:0]                   rd_idx,
    output logic [CNT_WIDTH-1:0]         rd_data,
    output logic [7:0]                   ovf,
    output logic                         irq
);

    localparam int NUM_CNT = 8;
    localparam int BP_W    = $clog2(FETCH_WIDTH + 1);
    localparam int LM_W    = $clog2(LOAD_ISSUE_WIDTH + 1);
    localparam int SM_W    = $clog2(STORE_ISSUE_WIDTH + 1);

    logic                         r_ic_miss;
    logic [FETCH_WIDTH-1:0]       r_br_pred;
    logic [LOAD_ISSUE_WIDTH-1:0]  r_load_miss;
    logic [STORE_ISSUE_WIDTH-1:0] r_store_miss;
    logic                         r_stld_fwd_fail;
    logic                         r_memdep_miss;
    logic                         r_br_miss;
    logic                         r_br_miss_dec;

    logic [BP_W-1:0]              w_br_pred_cnt;
    logic [LM_W-1:0]              w_load_miss_cnt;
    logic [SM_W-1:0]              w_store_miss_cnt;

    logic [CNT_WIDTH:0]           w_inc [NUM_CNT];
    logic [CNT_WIDTH:0]           w_sum [NUM_CNT];

    logic [CNT_WIDTH-1:0]         r_cnt [NUM_CNT];
    logic [7:0]                   r_ovf;
    logic [CNT_WIDTH-1:0]         r_rd_data;

    logic                         w_mask_wr;
    logic                         w_cnt_wr;

    // Capture stage: every strobe is registered unconditionally so the
    // accumulate stage works from a clean, aligned copy of the cycle's events.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ic_miss       <= 1'b0;
            r_br_pred       <= '0;
            r_load_miss     <= '0;
            r_store_miss    <= '0;
            r_stld_fwd_fail <= 1'b0;
            r_memdep_miss   <= 1'b0;
            r_br_miss       <= 1'b0;
            r_br_miss_dec   <= 1'b0;
        end else begin
            r_ic_miss       <= ev_ic_miss;
            r_br_pred       <= ev_br_pred;
            r_load_miss     <= ev_load_miss;
            r_store_miss    <= ev_store_miss;
            r_stld_fwd_fail <= ev_stld_fwd_fail;
            r_memdep_miss   <= ev_memdep_miss;
            r_br_miss       <= ev_br_miss;
            r_br_miss_dec   <= ev_br_miss_dec;
        end
    end

    // Multi-lane strobes collapse to a lane count for this cycle.
    always_comb begin
        w_br_pred_cnt    = '0;
        w_load_miss_cnt  = '0;
        w_store_miss_cnt = '0;
        for (int l = 0; l < FETCH_WIDTH; l++)
            w_br_pred_cnt = w_br_pred_cnt + BP_W'(r_br_pred[l]);
        for (int l = 0; l < LOAD_ISSUE_WIDTH; l++)
            w_load_miss_cnt = w_load_miss_cnt + LM_W'(r_load_miss[l]);
        for (int l = 0; l < STORE_ISSUE_WIDTH; l++)
            w_store_miss_cnt = w_store_miss_cnt + SM_W'(r_store_miss[l]);
    end

    // Per-counter increments and the carry-extended sums they produce.
    always_comb begin
        w_inc[0] = (CNT_WIDTH+1)'(r_ic_miss);
        w_inc[1] = (CNT_WIDTH+1)'(w_br_pred_cnt);
        w_inc[2] = (CNT_WIDTH+1)'(w_load_miss_cnt);
        w_inc[3] = (CNT_WIDTH+1)'(w_store_miss_cnt);
        w_inc[4] = (CNT_WIDTH+1)'(r_stld_fwd_fail);
        w_inc[5] = (CNT_WIDTH+1)'(r_memdep_miss);
        w_inc[6] = (CNT_WIDTH+1)'(r_br_miss);
        w_inc[7] = (CNT_WIDTH+1)'(r_br_miss_dec);
        for (int i = 0; i < NUM_CNT; i++)
            w_sum[i] = {1'b0, r_cnt[i]} + w_inc[i];
    end

    assign w_cnt_wr = wr_en && !w_mask_wr;

    // Accumulate stage: a CSR write wins over the increment of the same
    // counter; the carry-out of a real increment latches the sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++)
                r_cnt[i] <= '0;
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (w_cnt_wr && (wr_idx == 3'(i))) begin
                    r_cnt[i] <= wr_data;
                    r_ovf[i] <= 1'b0;
                end else if (!freeze && !inhibit[i] && (w_inc[i] != '0)) begin
                    r_cnt[i] <= w_sum[i][CNT_WIDTH-1:0];
                    if (w_sum[i][CNT_WIDTH])
                        r_ovf[i] <= 1'b1;
                end
            end
        end
    end

    // Registered read port; a same-cycle write is seen on the next read.
    always_ff @(posedge clk) begin
        if (rst)
            r_rd_data <= '0;
        else
            r_rd_data <= r_cnt[rd_idx];
    end

    assign rd_data = r_rd_data;
    assign ovf     = r_ovf;

`ifdef PERF_COUNTER_OVF_IRQ_EN
    logic [7:0] r_irq_mask;
    logic       r_irq;

    assign w_mask_wr = wr_en && (wr_idx == 3'd7) && wr_data[CNT_WIDTH-1];

    // Interrupt mask load and registered overflow interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_mask_wr)
                r_irq_mask <= wr_data[7:0];
            r_irq <= |(r_ovf & r_irq_mask);
        end
    end

    assign irq = r_irq;
`else
    assign w_mask_wr = 1'b0;
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_perf_event_accumulator.sv
// Testbench for perf_event_accumulator: table-driven vectors, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_perf_event_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        ev_ic_miss;
    logic [1:0]  ev_br_pred;
    logic [0:0]  ev_load_miss;
    logic [0:0]  ev_store_miss;
    logic        ev_stld_fwd_fail;
    logic        ev_memdep_miss;
    logic        ev_br_miss;
    logic        ev_br_miss_dec;
    logic        freeze;
    logic [7:0]  inhibit;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [63:0] wr_data;
    logic [2:0]  rd_idx;
    logic [63:0] rd_data;
    logic [7:0]  ovf;
    logic        irq;

    perf_event_accumulator #(
        .FETCH_WIDTH(2), .LOAD_ISSUE_WIDTH(1), .STORE_ISSUE_WIDTH(1), .CNT_WIDTH(64)
    ) dut (
        .clk(clk), .rst(rst), .ev_ic_miss(ev_ic_miss), .ev_br_pred(ev_br_pred),
        .ev_load_miss(ev_load_miss), .ev_store_miss(ev_store_miss),
        .ev_stld_fwd_fail(ev_stld_fwd_fail), .ev_memdep_miss(ev_memdep_miss),
        .ev_br_miss(ev_br_miss), .ev_br_miss_dec(ev_br_miss_dec), .freeze(freeze),
        .inhibit(inhibit), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .ovf(ovf), .irq(irq)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rs;
        logic        ic;
        logic [1:0]  bp;
        logic        lm;
        logic        sm;
        logic        sf;
        logic        md;
        logic        bm;
        logic        bmd;
        logic        frz;
        logic [7:0]  inh;
        logic        we;
        logic [2:0]  wi;
        logic [63:0] wd;
        logic [2:0]  ri;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic [63:0] expRd;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mCnt [8];
    int          mPend [8];
    logic [7:0]  mOvf;
    logic [7:0]  mMask;
    logic        mIrq;
    logic [63:0] expRd;
    logic [7:0]  expOvf;
    logic        expIrq;

    vec_t tbl [15];

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Drive one cycle of stimulus, advance the reference model across the
    // coming clock edge, then wait until just after that edge.
    task automatic applyStimulus(input stim_t s);
        logic [64:0] sum;
        logic        maskWr;
        rst              = s.rs;
        ev_ic_miss       = s.ic;
        ev_br_pred       = s.bp;
        ev_load_miss     = s.lm;
        ev_store_miss    = s.sm;
        ev_stld_fwd_fail = s.sf;
        ev_memdep_miss   = s.md;
        ev_br_miss       = s.bm;
        ev_br_miss_dec   = s.bmd;
        freeze           = s.frz;
        inhibit          = s.inh;
        wr_en            = s.we;
        wr_idx           = s.wi;
        wr_data          = s.wd;
        rd_idx           = s.ri;

        expRd = s.rs ? 64'd0 : mCnt[s.ri];
        if (s.rs) begin
            for (int i = 0; i < 8; i++) begin
                mCnt[i]  = '0;
                mPend[i] = 0;
            end
            mOvf  = '0;
            mMask = '0;
            mIrq  = 1'b0;
        end else begin
            maskWr = 1'b0;
`ifdef PERF_COUNTER_OVF_IRQ_EN
            maskWr = s.we && (s.wi == 3'd7) && s.wd[63];
            mIrq   = |(mOvf & mMask);
            if (maskWr)
                mMask = s.wd[7:0];
`endif
            for (int i = 0; i < 8; i++) begin
                if (s.we && !maskWr && (int'(s.wi) == i)) begin
                    mCnt[i] = s.wd;
                    mOvf[i] = 1'b0;
                end else if (!s.frz && !s.inh[i]) begin
                    sum     = {1'b0, mCnt[i]} + 65'(mPend[i]);
                    mCnt[i] = sum[63:0];
                    if (sum[64])
                        mOvf[i] = 1'b1;
                end
            end
            mPend[0] = int'(s.ic);
            mPend[1] = $countones(s.bp);
            mPend[2] = int'(s.lm);
            mPend[3] = int'(s.sm);
            mPend[4] = int'(s.sf);
            mPend[5] = int'(s.md);
            mPend[6] = int'(s.bm);
            mPend[7] = int'(s.bmd);
        end
        expOvf = mOvf;
        expIrq = mIrq;
        @(posedge clk);
        #2;
    endtask

    // Single comparison against a value computed by the bench.
    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output against the reference model.
    task automatic checkOutput(input string name);
        checkValue({name, ".rd_data"}, rd_data, expRd);
        checkValue({name, ".ovf"}, 64'(ovf), 64'(expOvf));
        checkValue({name, ".irq"}, 64'(irq), 64'(expIrq));
    endtask

    task automatic doReset();
        stim_t s;
        s    = idle();
        s.rs = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        checkOutput("reset");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;

        // I-cache miss burst on counter 0, then read back all other counters.
        for (int k = 0; k < 15; k++) begin
            tbl[k].s    = idle();
            tbl[k].s.ic = (k < 5);
            tbl[k].s.ri = (k < 8) ? 3'd0 : 3'(k - 7);
            if (k < 2 || k >= 8)
                tbl[k].expRd = 64'd0;
            else
                tbl[k].expRd = 64'((k - 1 < 5) ? k - 1 : 5);
        end

        doReset();
        for (int k = 0; k < 15; k++) begin
            applyStimulus(tbl[k].s);
            checkValue($sformatf("table[%0d]", k), rd_data, tbl[k].expRd);
            checkOutput($sformatf("table_model[%0d]", k));
        end

        // Two-lane branch prediction popcount, no inhibit.
        doReset();
        s = idle(); s.ri = 3'd1; s.bp = 2'b11;
        repeat (3) applyStimulus(s);
        s.bp = 2'b00;
        applyStimulus(s);
        applyStimulus(s);
        checkValue("brpred_total", rd_data, 64'd6);

        // Inhibit sampled in the accumulate cycle drops the later two bursts.
        doReset();
        s = idle(); s.ri = 3'd1; s.bp = 2'b11;
        applyStimulus(s);
        applyStimulus(s);
        s.inh = 8'h02;
        applyStimulus(s);
        s.bp = 2'b00;
        applyStimulus(s);
        s.inh = 8'h00;
        applyStimulus(s);
        checkValue("brpred_inhibit", rd_data, 64'd2);
        applyStimulus(s);
        checkValue("brpred_inhibit_hold", rd_data, 64'd2);

        // Wraparound sets the sticky flag; a later write clears it.
        doReset();
        s = idle(); s.ri = 3'd2; s.we = 1'b1; s.wi = 3'd2; s.wd = '1;
        applyStimulus(s);
        s.we = 1'b0; s.lm = 1'b1;
        applyStimulus(s);
        checkValue("ovf_preload", rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
        s.lm = 1'b0;
        applyStimulus(s);
        checkValue("ovf_set", 64'(ovf), 64'h04);
        applyStimulus(s);
        checkValue("ovf_wrapped", rd_data, 64'd0);
        s.we = 1'b1; s.wd = 64'd5;
        applyStimulus(s);
        checkValue("ovf_cleared", 64'(ovf), 64'h00);
        checkValue("rd_prewrite", rd_data, 64'd0);
        s.we = 1'b0;
        applyStimulus(s);
        checkValue("rd_postwrite", rd_data, 64'd5);

        // Write beats the in-flight increment of counter 4 only.
        doReset();
        s = idle(); s.sf = 1'b1; s.md = 1'b1;
        applyStimulus(s);
        s = idle(); s.we = 1'b1; s.wi = 3'd4; s.wd = 64'd100;
        applyStimulus(s);
        s = idle(); s.ri = 3'd4;
        applyStimulus(s);
        checkValue("wr_priority_cnt4", rd_data, 64'd100);
        s.ri = 3'd5;
        applyStimulus(s);
        checkValue("wr_priority_cnt5", rd_data, 64'd1);

        // Freeze blocks every counter; counting resumes when released.
        doReset();
        s = idle(); s.we = 1'b1; s.wi = 3'd6; s.wd = 64'd50;
        applyStimulus(s);
        s = idle(); s.frz = 1'b1;
        s.ic = 1'b1; s.bp = 2'b11; s.lm = 1'b1; s.sm = 1'b1;
        s.sf = 1'b1; s.md = 1'b1; s.bm = 1'b1; s.bmd = 1'b1;
        repeat (10) applyStimulus(s);
        s = idle(); s.frz = 1'b1;
        applyStimulus(s);
        for (int k = 0; k < 8; k++) begin
            s.ri = 3'(k);
            applyStimulus(s);
            checkValue($sformatf("freeze_cnt%0d", k), rd_data, (k == 6) ? 64'd50 : 64'd0);
        end
        s = idle(); s.ic = 1'b1;
        applyStimulus(s);
        s.ic = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        checkValue("unfreeze_cnt0", rd_data, 64'd1);
        checkValue("unfreeze_ovf", 64'(ovf), 64'h00);

`ifdef PERF_COUNTER_OVF_IRQ_EN
        // Mask write through index 7, then overflow counter 2.
        doReset();
        s = idle(); s.we = 1'b1; s.wi = 3'd7; s.wd = 64'h8000_0000_0000_0004;
        applyStimulus(s);
        s.wi = 3'd2; s.wd = '1;
        applyStimulus(s);
        s = idle(); s.lm = 1'b1; s.ri = 3'd7;
        applyStimulus(s);
        checkValue("mask_not_written_cnt7", rd_data, 64'd0);
        s.lm = 1'b0;
        applyStimulus(s);
        checkValue("irq_ovf_set", 64'(ovf), 64'h04);
        checkValue("irq_lag", 64'(irq), 64'd0);
        applyStimulus(s);
        checkValue("irq_asserted", 64'(irq), 64'd1);
        s.we = 1'b1; s.wi = 3'd2; s.wd = 64'd0;
        applyStimulus(s);
        checkValue("irq_still_high", 64'(irq), 64'd1);
        s.we = 1'b0;
        applyStimulus(s);
        checkValue("irq_cleared", 64'(irq), 64'd0);
`else
        // Without the interrupt option, index 7 with the MSB set is a plain write.
        doReset();
        s = idle(); s.we = 1'b1; s.wi = 3'd7; s.wd = 64'h8000_0000_0000_0004;
        applyStimulus(s);
        s = idle(); s.ri = 3'd7;
        applyStimulus(s);
        checkValue("cnt7_msb_write", rd_data, 64'h8000_0000_0000_0004);
        checkValue("irq_tied_low", 64'(irq), 64'd0);
`endif

        // Randomized traffic against the reference model.
        doReset();
        for (int n = 0; n < 600; n++) begin
            s     = idle();
            s.rs  = ($urandom_range(0, 63) == 0);
            s.ic  = 1'($urandom);
            s.bp  = 2'($urandom);
            s.lm  = 1'($urandom);
            s.sm  = 1'($urandom);
            s.sf  = 1'($urandom);
            s.md  = 1'($urandom);
            s.bm  = 1'($urandom);
            s.bmd = 1'($urandom);
            s.frz = ($urandom_range(0, 7) == 0);
            s.inh = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            s.we  = ($urandom_range(0, 9) == 0);
            s.wi  = 3'($urandom);
            if ($urandom_range(0, 1) == 0)
                s.wd = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
            else
                s.wd = {$urandom, $urandom};
            s.ri  = 3'($urandom);
            applyStimulus(s);
            checkOutput($sformatf("random[%0d]", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
